// File: rtl/scan_sel_gen.sv
`default_nettype none
// ============================================================================
// Module   : scan_sel_gen
// Purpose  : Steps a 3-to-8 decoder (E/In) through its channels with a
//            blank-then-dwell cadence; single-sweep or continuous scanning.
//            Optional channel skip mask enabled by macro SCAN_SKIP_MASK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module scan_sel_gen #(
  parameter int DWELL = 4,
  parameter int BLANK = 1
) (
  input  logic       clka,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       cont,
  input  logic [7:0] mask,
  output logic       E,
  output logic [2:0] In,
  output logic       busy,
  output logic       done,
  output logic       wrap
);

  localparam int C_CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);

  localparam logic [C_CNT_W-1:0] C_BLANK_LD = C_CNT_W'(BLANK - 1);
  localparam logic [C_CNT_W-1:0] C_DWELL_LD = C_CNT_W'(DWELL - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DWELL = 2'd2
  } state_t;

  state_t             r_state;
  logic [C_CNT_W-1:0] r_cnt;
  logic               r_cont;
  logic               r_e;
  logic [2:0]         r_in;
  logic               r_busy;
  logic               r_done;
  logic               r_wrap;

  logic [7:0]         w_chan_en;
  logic               w_any_en;
  logic [2:0]         w_first_ch;
  logic               w_next_found;
  logic [2:0]         w_next_ch;

`ifdef SCAN_SKIP_MASK_EN
  assign w_chan_en = ~mask;
`else
  logic w_unused_mask;
  assign w_chan_en     = 8'hFF;
  assign w_unused_mask = ^mask;
`endif

  assign w_any_en = |w_chan_en;

  // Descending search so the lowest qualifying channel is the one kept.
  always_comb begin
    w_first_ch   = 3'd0;
    w_next_found = 1'b0;
    w_next_ch    = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_chan_en[i]) begin
        w_first_ch = 3'(i);
        if (3'(i) > r_in) begin
          w_next_found = 1'b1;
          w_next_ch    = 3'(i);
        end
      end
    end
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cont  <= 1'b0;
      r_e     <= 1'b0;
      r_in    <= 3'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_wrap <= 1'b0;
      if (stop) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_e     <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (w_any_en) begin
                r_state <= S_BLANK;
                r_cnt   <= C_BLANK_LD;
                r_cont  <= cont;
                r_in    <= w_first_ch;
                r_busy  <= 1'b1;
              end else begin
                r_done  <= 1'b1;
              end
            end
          end

          S_BLANK: begin
            if (r_cnt == '0) begin
              r_state <= S_DWELL;
              r_cnt   <= C_DWELL_LD;
              r_e     <= 1'b1;
            end else begin
              r_cnt   <= r_cnt - C_CNT_ONE;
            end
          end

          S_DWELL: begin
            if (r_cnt == '0) begin
              r_e <= 1'b0;
              // An all-skipped mask mid-scan ends quietly, without done.
              if (!w_any_en) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
              end else if (w_next_found) begin
                r_state <= S_BLANK;
                r_cnt   <= C_BLANK_LD;
                r_in    <= w_next_ch;
              end else if (r_cont) begin
                r_state <= S_BLANK;
                r_cnt   <= C_BLANK_LD;
                r_in    <= w_first_ch;
                r_wrap  <= 1'b1;
              end else begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt - C_CNT_ONE;
            end
          end

          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_e     <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign E    = r_e;
  assign In   = r_in;
  assign busy = r_busy;
  assign done = r_done;
  assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_scan_sel_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_sel_gen
// Purpose  : Self-checking bench for scan_sel_gen; per-cycle expected traces
//            come from a channel-list model of the scan cadence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scan_sel_gen;

  localparam int TD  = 2;
  localparam int TBK = 1;

  typedef struct packed {
    logic       e;
    logic [2:0] in;
    logic       busy;
    logic       done;
    logic       wrap;
  } obs_t;

  logic       clka = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       cont;
  logic [7:0] mask;
  logic       E;
  logic [2:0] In;
  logic       busy;
  logic       done;
  logic       wrap;

  int         vectors     = 0;
  int         miscompares = 0;
  obs_t       exp_q[$];
  logic [2:0] model_in = 3'd0;

  always #5 clka = ~clka;

  scan_sel_gen #(
    .DWELL (TD),
    .BLANK (TBK)
  ) dut (
    .clka  (clka),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .cont  (cont),
    .mask  (mask),
    .E     (E),
    .In    (In),
    .busy  (busy),
    .done  (done),
    .wrap  (wrap)
  );

  // Expected outputs, one entry per cycle starting with the cycle after start.
  task automatic model_scan(input logic c, input logic [7:0] m, input int passes, input int stop_at);
    logic [7:0] en;
    int         chans[$];
    int         n_pass;
    logic [2:0] held;
`ifdef SCAN_SKIP_MASK_EN
    en = ~m;
`else
    en = 8'hFF | m;
`endif
    exp_q.delete();
    for (int ch = 0; ch < 8; ch++) if (en[ch]) chans.push_back(ch);
    if (chans.size() == 0) begin
      exp_q.push_back(obs_t'({1'b0, model_in, 1'b0, 1'b1, 1'b0}));
    end else begin
      n_pass = c ? passes : 1;
      for (int p = 0; p < n_pass; p++) begin
        for (int k = 0; k < chans.size(); k++) begin
          for (int b = 0; b < TBK; b++)
            exp_q.push_back(obs_t'({1'b0, 3'(chans[k]), 1'b1, 1'b0, (p > 0 && k == 0 && b == 0)}));
          for (int d = 0; d < TD; d++)
            exp_q.push_back(obs_t'({1'b1, 3'(chans[k]), 1'b1, 1'b0, 1'b0}));
        end
      end
      if (!c) exp_q.push_back(obs_t'({1'b0, 3'(chans[chans.size()-1]), 1'b0, 1'b1, 1'b0}));
    end
    if (stop_at >= 0) begin
      while (exp_q.size() > stop_at + 1) void'(exp_q.pop_back());
      held = exp_q[stop_at].in;
      exp_q.push_back(obs_t'({1'b0, held, 1'b0, 1'b0, 1'b0}));
      exp_q.push_back(obs_t'({1'b0, held, 1'b0, 1'b0, 1'b0}));
    end else begin
      held = exp_q[exp_q.size()-1].in;
      exp_q.push_back(obs_t'({1'b0, held, 1'b0, 1'b0, 1'b0}));
    end
  endtask

  task automatic test_reset();
    obs_t got;
    rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; mask = 8'h00;
    repeat (2) @(negedge clka);
    got = {E, In, busy, done, wrap};
    vectors++;
    if (got !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_values: got E=%b In=%0d busy=%b done=%b wrap=%b, expected all zero",
               got.e, got.in, got.busy, got.done, got.wrap);
    end
    rst = 1'b0;
    model_in = 3'd0;
    // Continuous scan up to the first dwell cycle of channel 5, then async reset.
    model_scan(1'b1, 8'h00, 1, -1);
    @(negedge clka); cont = 1'b1; start = 1'b1;
    for (int j = 0; j <= 5 * (TBK + TD) + TBK; j++) begin
      @(negedge clka);
      start = 1'b0;
      got = {E, In, busy, done, wrap};
      vectors++;
      if (got !== exp_q[j]) begin
        miscompares++;
        $display("FAIL reset_prescan cyc %0d: got E=%b In=%0d busy=%b done=%b wrap=%b, expected E=%b In=%0d busy=%b done=%b wrap=%b",
                 j, got.e, got.in, got.busy, got.done, got.wrap,
                 exp_q[j].e, exp_q[j].in, exp_q[j].busy, exp_q[j].done, exp_q[j].wrap);
      end
    end
    #2 rst = 1'b1;
    #1;
    got = {E, In, busy, done, wrap};
    vectors++;
    if (got !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_async: got E=%b In=%0d busy=%b done=%b wrap=%b, expected all zero",
               got.e, got.in, got.busy, got.done, got.wrap);
    end
    @(negedge clka); rst = 1'b0; cont = 1'b0;
    @(negedge clka);
    got = {E, In, busy, done, wrap};
    vectors++;
    if (got !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_after: got E=%b In=%0d busy=%b done=%b wrap=%b, expected all zero",
               got.e, got.in, got.busy, got.done, got.wrap);
    end
    model_in = 3'd0;
  endtask

  task automatic test_single_sweep();
    obs_t got;
    model_scan(1'b0, 8'h00, 1, -1);
    @(negedge clka); cont = 1'b0; mask = 8'h00; start = 1'b1;
    for (int j = 0; j < exp_q.size(); j++) begin
      @(negedge clka);
      start = 1'b0;
      got = {E, In, busy, done, wrap};
      vectors++;
      if (got !== exp_q[j]) begin
        miscompares++;
        $display("FAIL single_sweep cyc %0d: got E=%b In=%0d busy=%b done=%b wrap=%b, expected E=%b In=%0d busy=%b done=%b wrap=%b",
                 j, got.e, got.in, got.busy, got.done, got.wrap,
                 exp_q[j].e, exp_q[j].in, exp_q[j].busy, exp_q[j].done, exp_q[j].wrap);
      end
    end
    model_in = exp_q[exp_q.size()-1].in;
  endtask

  task automatic test_continuous_stop();
    obs_t got;
    int   stop_at;
    stop_at = 8 * (TBK + TD) + 3 * (TBK + TD) + TBK;  // second pass, channel 3 dwell
    model_scan(1'b1, 8'h00, 2, stop_at);
    @(negedge clka); cont = 1'b1; mask = 8'h00; start = 1'b1;
    for (int j = 0; j < exp_q.size(); j++) begin
      @(negedge clka);
      start = 1'b0; stop = 1'b0;
      got = {E, In, busy, done, wrap};
      vectors++;
      if (got !== exp_q[j]) begin
        miscompares++;
        $display("FAIL continuous_stop cyc %0d: got E=%b In=%0d busy=%b done=%b wrap=%b, expected E=%b In=%0d busy=%b done=%b wrap=%b",
                 j, got.e, got.in, got.busy, got.done, got.wrap,
                 exp_q[j].e, exp_q[j].in, exp_q[j].busy, exp_q[j].done, exp_q[j].wrap);
      end
      if (j == stop_at) stop = 1'b1;
    end
    cont = 1'b0;
    model_in = exp_q[exp_q.size()-1].in;
  endtask

  task automatic test_start_stop_same();
    obs_t got;
    obs_t want;
    want = obs_t'({1'b0, model_in, 1'b0, 1'b0, 1'b0});
    @(negedge clka); start = 1'b1; stop = 1'b1; cont = 1'b0; mask = 8'h00;
    for (int j = 0; j < 3; j++) begin
      @(negedge clka);
      got = {E, In, busy, done, wrap};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL start_stop_same cyc %0d: got E=%b In=%0d busy=%b done=%b wrap=%b, expected idle In=%0d",
                 j, got.e, got.in, got.busy, got.done, got.wrap, want.in);
      end
    end
    start = 1'b0; stop = 1'b0;
  endtask

`ifdef SCAN_SKIP_MASK_EN
  task automatic test_mask();
    obs_t got;
    obs_t t;
    logic [7:0] masks [2];
    masks[0] = 8'b1010_1010;
    masks[1] = 8'hFF;
    for (int s = 0; s < 2; s++) begin
      model_scan(1'b0, masks[s], 1, -1);
      @(negedge clka); cont = 1'b0; mask = masks[s]; start = 1'b1;
      for (int j = 0; j < exp_q.size(); j++) begin
        @(negedge clka);
        start = 1'b0;
        got = {E, In, busy, done, wrap};
        vectors++;
        if (got !== exp_q[j]) begin
          miscompares++;
          $display("FAIL mask_sweep mask=%h cyc %0d: got E=%b In=%0d busy=%b done=%b wrap=%b, expected E=%b In=%0d busy=%b done=%b wrap=%b",
                   masks[s], j, got.e, got.in, got.busy, got.done, got.wrap,
                   exp_q[j].e, exp_q[j].in, exp_q[j].busy, exp_q[j].done, exp_q[j].wrap);
        end
      end
      model_in = exp_q[exp_q.size()-1].in;
    end
    // Mask goes all-ones during channel 2: dwell finishes, then IDLE with no done.
    model_scan(1'b0, 8'b1111_1000, 1, -1);
    t = exp_q[3 * (TBK + TD)];
    t.done = 1'b0;
    exp_q[3 * (TBK + TD)] = t;
    @(negedge clka); cont = 1'b0; mask = 8'h00; start = 1'b1;
    for (int j = 0; j < exp_q.size(); j++) begin
      @(negedge clka);
      start = 1'b0;
      got = {E, In, busy, done, wrap};
      vectors++;
      if (got !== exp_q[j]) begin
        miscompares++;
        $display("FAIL mask_midscan cyc %0d: got E=%b In=%0d busy=%b done=%b wrap=%b, expected E=%b In=%0d busy=%b done=%b wrap=%b",
                 j, got.e, got.in, got.busy, got.done, got.wrap,
                 exp_q[j].e, exp_q[j].in, exp_q[j].busy, exp_q[j].done, exp_q[j].wrap);
      end
      if (j == 2 * (TBK + TD)) mask = 8'hFF;
    end
    mask = 8'h00;
    model_in = exp_q[exp_q.size()-1].in;
  endtask
`endif

  task automatic test_back_to_back();
    obs_t       got;
    logic       c;
    logic [7:0] m;
    int         passes;
    int         nb;
    int         stop_at;
    int         gap;
    for (int it = 0; it < 14; it++) begin
      c = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       m = 8'h00;
        1:       m = 8'hFF;
        default: m = 8'($urandom);
      endcase
      passes = $urandom_range(1, 2);
      model_scan(c, m, passes, -1);
      nb = 0;
      for (int j = 0; j < exp_q.size(); j++) if (exp_q[j].busy) nb++;
      stop_at = -1;
      if (nb > 0 && (c || $urandom_range(0, 2) == 0)) stop_at = $urandom_range(0, nb - 1);
      model_scan(c, m, passes, stop_at);
      @(negedge clka); cont = c; mask = m; start = 1'b1;
      for (int j = 0; j < exp_q.size(); j++) begin
        @(negedge clka);
        start = 1'b0; stop = 1'b0;
        got = {E, In, busy, done, wrap};
        vectors++;
        if (got !== exp_q[j]) begin
          miscompares++;
          $display("FAIL back_to_back it %0d cont=%b mask=%h stop_at=%0d cyc %0d: got E=%b In=%0d busy=%b done=%b wrap=%b, expected E=%b In=%0d busy=%b done=%b wrap=%b",
                   it, c, m, stop_at, j, got.e, got.in, got.busy, got.done, got.wrap,
                   exp_q[j].e, exp_q[j].in, exp_q[j].busy, exp_q[j].done, exp_q[j].wrap);
        end
        if (j == stop_at) begin
          stop = 1'b1;
          start = 1'($urandom_range(0, 1));
        end else if (exp_q[j].busy) begin
          // Mid-scan start/cont noise must not disturb the running sequence.
          start = 1'($urandom_range(0, 1));
          cont  = 1'($urandom_range(0, 1));
        end
      end
      model_in = exp_q[exp_q.size()-1].in;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clka);
        got = {E, In, busy, done, wrap};
        vectors++;
        if (got !== obs_t'({1'b0, model_in, 1'b0, 1'b0, 1'b0})) begin
          miscompares++;
          $display("FAIL idle_gap it %0d: got E=%b In=%0d busy=%b done=%b wrap=%b, expected idle In=%0d",
                   it, got.e, got.in, got.busy, got.done, got.wrap, model_in);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_sweep();
    test_continuous_stop();
    test_start_stop_same();
`ifdef SCAN_SKIP_MASK_EN
    test_mask();
`endif
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scan_sel_gen.md
# scan_sel_gen

Sequencing stage that drives the enable and 3-bit select inputs of the 3-to-8 decoder (`E`, `In`), so the decoder's one-hot outputs are stepped through the channels under clock control. Each channel step has a blanking interval (decoder disabled) followed by a dwell interval (decoder enabled on that channel). The block supports single-sweep and continuous scanning, a start/stop control interface, and status outputs. It sits directly upstream of the decoder; its `E` and `In` connect straight to the decoder's `E` and `In`.

## Interface
- `DWELL`, default 4: cycles `E` is held high per channel; legal range ≥1.
- `BLANK`, default 1: cycles `E` is held low before each channel's dwell; legal range ≥1.
- `clka`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  level-sampled; begins a scan when the block is idle.
- `stop`  input  1  level-sampled; aborts the scan.
- `cont`  input  1  sampled with `start`: 1 = continuous scan, 0 = single sweep.
- `mask`  input  8  channel skip mask; bit n = 1 skips channel n. Used only when `SCAN_SKIP_MASK_EN` is defined.
- `E`  output  1  decoder enable (drives decoder `E`).
- `In`  output  3  channel select (drives decoder `In`).
- `busy`  output  1  high whenever the block is not in IDLE.
- `done`  output  1  one-cycle pulse when a single sweep completes.
- `wrap`  output  1  one-cycle pulse when `In` wraps from the last channel back to the first.

## Operation
- Reset values (applied asynchronously):
  - state = IDLE;
  - `E`=0, `In`=3'b000, `busy`=0, `done`=0, `wrap`=0;
  - dwell/blank counter = 0; latched cont = 0.
- States: IDLE, BLANK, DWELL.
- IDLE → BLANK: when `start`=1 and `stop`=0.
  - `cont` is latched at this edge.
  - `In` loads the first enabled channel.
- BLANK:
  - `E`=0.
  - After exactly `BLANK` cycles, go to DWELL.
- DWELL:
  - `E`=1.
  - After exactly `DWELL` cycles, advance `In` to the next enabled channel in ascending order, then go to BLANK.
  - If the current channel is the last enabled channel:
    - continuous mode: wrap to the first enabled channel, pulse `wrap`, go to BLANK;
    - single-sweep mode: go to IDLE, pulse `done`, leave `In` holding the last channel.
- `stop`=1 in any state takes priority:
  - next state is IDLE, `E`=0;
  - no `done` or `wrap` pulse;
  - `In` holds its value.
- `start` while `busy`=1 is ignored; `cont` is not re-sampled mid-scan.
- `start` and `stop` high in the same cycle in IDLE: the block stays in IDLE.
- Counter width is $clog2(max(DWELL,BLANK)+1) bits. The counter reloads on every state entry and never wraps inside a state.
- Reset asserted mid-scan: immediate return to reset values; no `done` pulse.

## Timing
- Let start be sampled at edge k.
  - From k+1: BLANK cycles with `E`=0.
  - Then DWELL cycles with `E`=1.
- One channel step lasts BLANK+DWELL cycles.
- A full sweep of N enabled channels lasts N·(BLANK+DWELL) cycles. `busy` is high throughout.
- `done` is high in the first IDLE cycle after the final dwell.
- `wrap` is high in the first BLANK cycle of the new pass.
- `In` changes only on the BLANK-entry edge, so `In` is always stable while `E`=1.

## Configuration
- `SCAN_SKIP_MASK_EN` defined:
  - channels whose `mask` bit is 1 are skipped; `mask` is sampled at each channel advance.
  - `mask`=8'hFF at `start`: the block stays in IDLE and pulses `done` for one cycle.
  - `mask`=8'hFF during a scan: the block finishes the current dwell, then returns to IDLE without a `done` pulse.
- `SCAN_SKIP_MASK_EN` not defined: `mask` is ignored and all 8 channels (0–7) are scanned.

## Test plan
- Reset: assert `rst` mid-DWELL on channel 5 → `E`=0, `In`=0, `busy`=0 immediately, with no clock edge required.
- Single sweep, DWELL=2, BLANK=1, `cont`=0:
  - `start` pulse at edge k → `In` steps 0..7;
  - `E` pattern per channel is 0,1,1;
  - `busy` high for 24 cycles;
  - `done` pulses at k+25 with `In`=7.
- Continuous, DWELL=2, BLANK=1: `wrap` pulses every 24 cycles with `In`=0. Raise `stop` at channel 3 → `E`=0 and `busy`=0 next cycle, `In`=3, no `done`.
- Same-cycle `start`+`stop` in IDLE → `busy` stays 0. `start` during a scan → no restart, sequence unchanged.
- With `SCAN_SKIP_MASK_EN`, `mask`=8'b1010_1010, single sweep → `In` visits only 0,2,4,6; `done` fires after 4 channel steps.
- With `SCAN_SKIP_MASK_EN`, `mask`=8'hFF at `start` → `busy` stays 0 and `done` pulses once.
